unidade_store: RTL and testbench
================================

# unidade_store

Store path of the MEM stage of the MIPS processor: the counterpart to the write-back selection that feeds the register file. It takes a register value from a `sw`, `sh` or `sb` instruction and writes it into data memory. The memory is word-wide, has no byte enables and uses a req/ack handshake, so sub-word stores are performed as read-modify-write. The pipeline is held with `stall` until the store completes or is rejected.

## Interface
- `TIMEOUT`, default 255: maximum cycles waited for `mem_ack` in one memory phase; 0 disables the timeout.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_write` in 1: store request from the MEM stage (level, held while `stall`=1).
- `tipo` in 2: store size; 00 byte, 01 half, 10 word, 11 invalid.
- `endereco` in 32: byte address (ALU result).
- `dado_reg` in 32: rt value to store.
- `stall` out 1: hold the pipeline.
- `concluido` out 1: one-cycle pulse, store committed.
- `erro` out 1: one-cycle pulse, store rejected (misaligned, invalid `tipo` or timeout).
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr` out 32: word address; bits [1:0] are always 0.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data; valid in the cycle `mem_ack`=1.
- `mem_ack` in 1: completes the current request.

## Operation
- States: OCIOSO, LEITURA, ESCRITA, FIM.
- Big-endian lanes: byte offset k = `endereco`[1:0] occupies bits [31-8k : 24-8k].
- **OCIOSO**, with `mem_write`=1:
  - Capture `endereco`, `dado_reg` and `tipo` into internal registers; later input changes are ignored.
  - Alignment check: half requires `endereco`[0]=0; word requires `endereco`[1:0]=0; `tipo`=11 always fails.
  - Fail: go to FIM with the error flag set; no memory access.
  - Word: load the write buffer with `dado_reg` and go to ESCRITA.
  - Byte or half: go to LEITURA.
- **LEITURA**:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = {addr[31:2], 2'b00}.
  - On `mem_ack`, merge and go to ESCRITA.
  - Byte merge: replace lane k with `dado_reg`[7:0].
  - Half merge: offset 0 replaces [31:16], offset 2 replaces [15:0], both with `dado_reg`[15:0].
  - All other bits come from `mem_rdata`.
- **ESCRITA**: `mem_req`=1, `mem_we`=1, `mem_wdata` = buffer. On `mem_ack`, go to FIM with the success flag set.
- **Timeout**: a cycle counter is cleared on entry to LEITURA or ESCRITA and increments each cycle without `mem_ack`.
  - When it reaches `TIMEOUT` (nonzero), go to FIM with the error flag set.
  - The request is dropped; no write is performed.
- **FIM**:
  - Exactly one of `concluido` or `erro` is 1.
  - `stall`=0 and `mem_write` is ignored (the pipeline advances at this edge).
  - Next state is always OCIOSO.
- **Outputs**:
  - `stall` = (state≠OCIOSO and state≠FIM) or (state=OCIOSO and `mem_write`). This is the only combinational output.
  - All other outputs are decoded from registered state or buffers.
- **Reset values**: state OCIOSO; `mem_req`, `mem_we`, `concluido`, `erro` = 0; `mem_addr`, `mem_wdata`, counter, buffers = 0.

## Timing
- **Word store, ack in the first cycle**:
  - c0: accept, `stall`=1.
  - c1: ESCRITA with `mem_ack`.
  - c2: FIM, `concluido`=1, `stall`=0.
  - 3 cycles total.
- **Byte/half store, ack in the first cycle of each phase**: c0 accept, c1 read, c2 write, c3 FIM. 4 cycles total.
- **Each extra wait cycle** on `mem_ack` adds one cycle.
- **Misaligned or invalid store**: c0 accept with `stall`=1, c1 FIM with `erro`=1. `mem_req` is never asserted.
- **`mem_req`** stays asserted continuously from phase entry through the ack cycle, and deasserts on the following edge. Between LEITURA and ESCRITA, `mem_req` stays high and `mem_we` rises.
- **`mem_ack` outside LEITURA/ESCRITA** is ignored.
- **Reset mid-transaction**: on the next edge, state OCIOSO and `mem_req`=0. The partial transaction is abandoned, and no `concluido` or `erro` pulse is produced.
- **Back-to-back stores**: a new store can be accepted in the cycle after FIM.

## Test plan
- sw: addr 0x0000_0010, dado 0xDEADBEEF, ack immediate → one write of 0xDEADBEEF at 0x10; `concluido` in c2; `stall` high in c0–c1.
- sb: addr 0x13, dado 0x0000_00AB, rdata 0x11223344 → write 0x112233AB at 0x10; `concluido` in c3.
- sh: addr 0x22, dado 0x0000_CAFE, rdata 0x11223344, ack delayed 2 cycles per phase → write 0x1122CAFE at 0x20; `concluido` in c7.
- sh at 0x21, sw at 0x12, and `tipo`=11 → `erro` pulse in c1; `mem_req` never 1.
- `TIMEOUT`=4, no `mem_ack` during a sw → `erro` after 4 request cycles; `mem_req` drops; no `concluido`.
- `reset` in the first write cycle of an sb → next cycle `mem_req`=0, `stall` follows `mem_write`; a following sw completes normally.

Source files
------------

// File: rtl/unidade_store.sv
// rtl/unidade_store.sv - MEM-stage store unit: sw/sh/sb into word-wide memory via read-modify-write
module unidade_store #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic [1:0]  tipo,
   input  logic [31:0] endereco,
   input  logic [31:0] dado_reg,
   output logic        stall,
   output logic        concluido,
   output logic        erro,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, FIM} estado_t;

   localparam logic [31:0] LIMITE = 32'(TIMEOUT);

   estado_t     estado, proximo;
   logic [31:0] end_r;
   logic [31:0] buf_r;
   logic [31:0] cont;
   logic [15:0] dado_r;
   logic [1:0]  tipo_r;
   logic        ok_r;
   logic        alinhado;
   logic        estouro;
   logic [31:0] mesclado;

   always_comb begin
      alinhado = 1'b0;
      case (tipo)
         2'b00:   alinhado = 1'b1;
         2'b01:   alinhado = ~endereco[0];
         2'b10:   alinhado = (endereco[1:0] == 2'b00);
         default: alinhado = 1'b0;
      endcase
   end

   // The ack cycle never counts as a wait cycle, so an ack on the last allowed cycle still wins.
   assign estouro = (LIMITE != 32'd0) && !mem_ack && (cont + 32'd1 == LIMITE);

   // Big-endian lanes: byte offset 0 is the most significant byte.
   always_comb begin
      mesclado = mem_rdata;
      if (tipo_r == 2'b01) begin
         if (end_r[1]) mesclado[15:0]  = dado_r;
         else          mesclado[31:16] = dado_r;
      end else begin
         case (end_r[1:0])
            2'b00:   mesclado[31:24] = dado_r[7:0];
            2'b01:   mesclado[23:16] = dado_r[7:0];
            2'b10:   mesclado[15:8]  = dado_r[7:0];
            default: mesclado[7:0]   = dado_r[7:0];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) estado <= OCIOSO;
      else       estado <= proximo;
   end

   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO: begin
            if (mem_write) begin
               if (!alinhado)            proximo = FIM;
               else if (tipo == 2'b10)   proximo = ESCRITA;
               else                      proximo = LEITURA;
            end
         end
         LEITURA: begin
            if (mem_ack)      proximo = ESCRITA;
            else if (estouro) proximo = FIM;
         end
         ESCRITA: begin
            if (mem_ack || estouro) proximo = FIM;
         end
         default: proximo = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         end_r  <= 32'd0;
         buf_r  <= 32'd0;
         cont   <= 32'd0;
         dado_r <= 16'd0;
         tipo_r <= 2'b00;
         ok_r   <= 1'b0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (mem_write) begin
                  end_r  <= endereco;
                  dado_r <= dado_reg[15:0];
                  tipo_r <= tipo;
                  ok_r   <= 1'b0;
                  cont   <= 32'd0;
                  if (tipo == 2'b10) buf_r <= dado_reg;
               end
            end
            LEITURA: begin
               if (mem_ack) begin
                  buf_r <= mesclado;
                  cont  <= 32'd0;
               end else begin
                  cont <= cont + 32'd1;
               end
            end
            ESCRITA: begin
               if (mem_ack) ok_r <= 1'b1;
               else         cont <= cont + 32'd1;
            end
            default: ;
         endcase
      end
   end

   assign stall     = (estado == LEITURA) || (estado == ESCRITA) || (estado == OCIOSO && mem_write);
   assign mem_req   = (estado == LEITURA) || (estado == ESCRITA);
   assign mem_we    = (estado == ESCRITA);
   assign mem_addr  = {end_r[31:2], 2'b00};
   assign mem_wdata = buf_r;
   assign concluido = (estado == FIM) && ok_r;
   assign erro      = (estado == FIM) && !ok_r;

endmodule

// File: tb/tb_unidade_store.sv
// tb/tb_unidade_store.sv - scoreboard bench for unidade_store
module tb_unidade_store;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write;
   logic [1:0]  tipo;
   logic [31:0] endereco;
   logic [31:0] dado_reg;
   logic        stall;
   logic        concluido;
   logic        erro;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   unidade_store #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .mem_write(mem_write), .tipo(tipo),
      .endereco(endereco), .dado_reg(dado_reg), .stall(stall),
      .concluido(concluido), .erro(erro), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tipo_ev;
      logic [31:0] addr;
      logic [31:0] dado;
      int          rel;
   } evento_t;

   localparam int EV_R = 0;
   localparam int EV_W = 1;
   localparam int EV_C = 2;
   localparam int EV_E = 3;

   evento_t fila[$];
   int checks = 0;
   int erros  = 0;
   int ciclo  = 0;
   int t0     = 0;
   int fim_rel = 0;
   bit ativo  = 1'b0;
   int atraso = 0;
   bit ack_on = 1'b1;

   always @(posedge clk) ciclo <= ciclo + 1;

   task automatic checar(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      checks++;
      if (atual !== esperado) begin
         erros++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nome, atual, esperado, $time);
      end
   endtask

   task automatic esperar(input int k, input logic [31:0] a, input logic [31:0] d, input int rel);
      evento_t e;
      e.tipo_ev = k; e.addr = a; e.dado = d; e.rel = rel;
      fila.push_back(e);
   endtask

   task automatic observar(input int k, input logic [31:0] a, input logic [31:0] d, input int rel);
      evento_t e;
      if (fila.size() == 0) begin
         checks++;
         erros++;
         $display("FAIL evento_inesperado: got kind %0d addr %h data %h at c%0d, expected none", k, a, d, rel);
         return;
      end
      e = fila.pop_front();
      checar("ev_tipo", k, e.tipo_ev);
      checar("ev_addr", a, e.addr);
      checar("ev_dado", d, e.dado);
      checar("ev_ciclo", rel, e.rel);
   endtask

   // Memory model: acks each phase after `atraso` wait cycles.
   initial begin
      logic rq_ant;
      logic we_ant;
      int   espera;
      rq_ant = 1'b0;
      we_ant = 1'b0;
      espera = 0;
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req && (!rq_ant || mem_we != we_ant)) espera = 0;
         mem_ack = mem_req && ack_on && (espera == atraso);
         if (mem_req && !mem_ack) espera++;
         rq_ant = mem_req;
         we_ant = mem_we;
      end
   end

   // Monitor: per-cycle stall/req model plus event scoreboard.
   initial begin
      int   rel;
      logic e_st;
      logic e_rq;
      forever begin
         @(negedge clk);
         if (!reset) begin
            rel = ciclo - t0;
            if (ativo) begin
               e_st = (rel < fim_rel);
               e_rq = (rel >= 1) && (rel < fim_rel);
            end else begin
               e_st = mem_write;
               e_rq = 1'b0;
            end
            checar("stall", stall, e_st);
            checar("mem_req", mem_req, e_rq);
            if (mem_req && mem_ack)
               observar(mem_we ? EV_W : EV_R, mem_addr, mem_we ? mem_wdata : 32'd0, rel);
            if (concluido) observar(EV_C, 32'd0, 32'd0, rel);
            if (erro)      observar(EV_E, 32'd0, 32'd0, rel);
         end
      end
   end

   task automatic loja(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       input int atr, input bit ack, input int fim);
      atraso = atr;
      ack_on = ack;
      t0 = ciclo;
      fim_rel = fim;
      ativo = 1'b1;
      mem_write = 1'b1;
      tipo = t;
      endereco = a;
      dado_reg = d;
      @(posedge clk); #1;
      endereco = ~a;
      dado_reg = ~d;
      tipo = ~t;
      repeat (fim) @(posedge clk);
      #1;
      mem_write = 1'b0;
      ativo = 1'b0;
      checar("fila_vazia", fila.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      mem_write = 1'b0;
      tipo = 2'b00;
      endereco = 32'd0;
      dado_reg = 32'd0;
      mem_rdata = 32'h1122_3344;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checar("rst_mem_req", mem_req, 1'b0);
      checar("rst_mem_we", mem_we, 1'b0);
      checar("rst_concluido", concluido, 1'b0);
      checar("rst_erro", erro, 1'b0);
      checar("rst_stall", stall, 1'b0);
      checar("rst_mem_addr", mem_addr, 32'd0);
      checar("rst_mem_wdata", mem_wdata, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // sw, immediate ack
      esperar(EV_W, 32'h10, 32'hDEAD_BEEF, 1);
      esperar(EV_C, 32'd0, 32'd0, 2);
      loja(2'b10, 32'h10, 32'hDEAD_BEEF, 0, 1'b1, 2);

      // sb offset 3
      esperar(EV_R, 32'h10, 32'd0, 1);
      esperar(EV_W, 32'h10, 32'h1122_33AB, 2);
      esperar(EV_C, 32'd0, 32'd0, 3);
      loja(2'b00, 32'h13, 32'h0000_00AB, 0, 1'b1, 3);

      // sh offset 2, two wait cycles per phase
      esperar(EV_R, 32'h20, 32'd0, 3);
      esperar(EV_W, 32'h20, 32'h1122_CAFE, 6);
      esperar(EV_C, 32'd0, 32'd0, 7);
      loja(2'b01, 32'h22, 32'h0000_CAFE, 2, 1'b1, 7);

      // remaining lanes; upper dado_reg bits must not leak
      esperar(EV_R, 32'h40, 32'd0, 1);
      esperar(EV_W, 32'h40, 32'h5A22_3344, 2);
      esperar(EV_C, 32'd0, 32'd0, 3);
      loja(2'b00, 32'h40, 32'hFFFF_FF5A, 0, 1'b1, 3);

      esperar(EV_R, 32'h48, 32'd0, 1);
      esperar(EV_W, 32'h48, 32'h1177_3344, 2);
      esperar(EV_C, 32'd0, 32'd0, 3);
      loja(2'b00, 32'h49, 32'h0000_0077, 0, 1'b1, 3);

      esperar(EV_R, 32'h4C, 32'd0, 1);
      esperar(EV_W, 32'h4C, 32'h1122_6644, 2);
      esperar(EV_C, 32'd0, 32'd0, 3);
      loja(2'b00, 32'h4E, 32'h0000_0066, 0, 1'b1, 3);

      esperar(EV_R, 32'h44, 32'd0, 1);
      esperar(EV_W, 32'h44, 32'hBEEF_3344, 2);
      esperar(EV_C, 32'd0, 32'd0, 3);
      loja(2'b01, 32'h44, 32'h1234_BEEF, 0, 1'b1, 3);

      // rejected stores
      esperar(EV_E, 32'd0, 32'd0, 1);
      loja(2'b01, 32'h21, 32'h0000_1234, 0, 1'b1, 1);
      esperar(EV_E, 32'd0, 32'd0, 1);
      loja(2'b10, 32'h12, 32'h1234_5678, 0, 1'b1, 1);
      esperar(EV_E, 32'd0, 32'd0, 1);
      loja(2'b11, 32'h10, 32'h1234_5678, 0, 1'b1, 1);

      // timeout boundary: three waits succeed, no ack times out after four request cycles
      esperar(EV_W, 32'h34, 32'hA5A5_5A5A, 4);
      esperar(EV_C, 32'd0, 32'd0, 5);
      loja(2'b10, 32'h34, 32'hA5A5_5A5A, 3, 1'b1, 5);

      esperar(EV_E, 32'd0, 32'd0, 5);
      loja(2'b10, 32'h30, 32'h0F0F_0F0F, 0, 1'b0, 5);

      // reset during the first write cycle of an sb
      esperar(EV_R, 32'h10, 32'd0, 4);
      atraso = 3;
      ack_on = 1'b1;
      t0 = ciclo;
      fim_rel = 6;
      ativo = 1'b1;
      mem_write = 1'b1;
      tipo = 2'b00;
      endereco = 32'h13;
      dado_reg = 32'h0000_00AB;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      mem_write = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      ativo = 1'b0;
      checar("fila_vazia_reset", fila.size(), 0);

      esperar(EV_W, 32'h50, 32'h0BAD_F00D, 1);
      esperar(EV_C, 32'd0, 32'd0, 2);
      loja(2'b10, 32'h50, 32'h0BAD_F00D, 0, 1'b1, 2);

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, erros);
      $finish;
   end

endmodule
